// File: rtl/mmcm_ps_servo.sv
// Closed-loop phase servo for the slave MMCM. It integrates signed phase-error
// samples over a fixed window. From each window it issues a bounded burst of
// PSEN fine steps. It also tracks lock status and the net phase offset applied.
module mmcm_ps_servo #(
  parameter int ERR_W        = 8,
  parameter int ACC_W        = 16,
  parameter int WINDOW       = 64,
  parameter int DEADBAND     = 4,
  parameter int GAIN_SHIFT   = 2,
  parameter int MAX_STEPS    = 8,
  parameter int PS_TIMEOUT   = 64,
  parameter int LOCK_WINDOWS = 4,
  parameter int PSCNT_W      = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      servo_en,
  input  logic                      err_valid,
  input  logic signed [ERR_W-1:0]   err_in,
  output logic                      ps_en,
  output logic                      ps_incdec,
  input  logic                      ps_done,
  output logic                      locked,
  output logic signed [PSCNT_W-1:0] ps_count,
  output logic                      timeout_err
);

  localparam int SCNT_W = $clog2(WINDOW + 1);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int TMR_W  = $clog2(PS_TIMEOUT + 1);
  localparam int QCNT_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic signed [ACC_W-1:0]   ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]   ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PSCNT_W-1:0] PSCNT_MAX = {1'b0, {(PSCNT_W-1){1'b1}}};
  localparam logic signed [PSCNT_W-1:0] PSCNT_MIN = {1'b1, {(PSCNT_W-1){1'b0}}};

  typedef enum logic [1:0] {StAccum, StDecide, StStep, StWait} state_e;

  state_e                    r_state,   w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc,     w_acc_nxt;
  logic [SCNT_W-1:0]         r_scnt,    w_scnt_nxt;
  logic [QCNT_W-1:0]         r_quiet,   w_quiet_nxt;
  logic [STEP_W-1:0]         r_steps,   w_steps_nxt;
  logic [TMR_W-1:0]          r_timer,   w_timer_nxt;
  logic                      r_incdec,  w_incdec_nxt;
  logic                      r_locked,  w_locked_nxt;
  logic signed [PSCNT_W-1:0] r_count,   w_count_nxt;
  logic                      r_tout,    w_tout_nxt;

  logic [ACC_W:0]            w_sum;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic [ACC_W-1:0]          w_abs;
  logic [ACC_W-1:0]          w_shr;
  logic [STEP_W-1:0]         w_steps;
  logic [QCNT_W-1:0]         w_quiet_inc;

  // Saturating window accumulator add and step-count derivation
  always_comb begin
    w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W + 1 - ERR_W){err_in[ERR_W-1]}}, err_in};
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_acc_sum = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_acc_sum = w_sum[ACC_W-1:0];
    end
    // The unsigned magnitude of ACC_MIN still fits in ACC_W bits.
    w_abs = r_acc[ACC_W-1] ? (~r_acc + ACC_W'(1)) : r_acc;
    w_shr = w_abs >> GAIN_SHIFT;
    if (w_shr == '0) begin
      w_steps = STEP_W'(1);
    end else if (w_shr > ACC_W'(MAX_STEPS)) begin
      w_steps = STEP_W'(MAX_STEPS);
    end else begin
      w_steps = w_shr[STEP_W-1:0];
    end
    w_quiet_inc = (r_quiet == QCNT_W'(LOCK_WINDOWS)) ? r_quiet : r_quiet + QCNT_W'(1);
  end

  // Next-state logic: accumulate, decide, then step/wait handshake with the MMCM
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_scnt_nxt   = r_scnt;
    w_quiet_nxt  = r_quiet;
    w_steps_nxt  = r_steps;
    w_timer_nxt  = '0;
    w_incdec_nxt = r_incdec;
    w_locked_nxt = r_locked;
    w_count_nxt  = r_count;
    w_tout_nxt   = r_tout;
    unique case (r_state)
      StAccum: begin
        if (!servo_en) begin
          w_acc_nxt  = '0;
          w_scnt_nxt = '0;
        end else if (err_valid) begin
          w_acc_nxt  = w_acc_sum;
          w_scnt_nxt = r_scnt + SCNT_W'(1);
          if (r_scnt == SCNT_W'(WINDOW - 1)) begin
            w_state_nxt = StDecide;
          end
        end
      end
      StDecide: begin
        w_acc_nxt  = '0;
        w_scnt_nxt = '0;
        if (w_abs <= ACC_W'(DEADBAND)) begin
          w_quiet_nxt  = w_quiet_inc;
          w_locked_nxt = r_locked | (w_quiet_inc == QCNT_W'(LOCK_WINDOWS));
          w_state_nxt  = StAccum;
        end else begin
          w_locked_nxt = 1'b0;
          w_quiet_nxt  = '0;
          w_steps_nxt  = w_steps;
          w_incdec_nxt = (r_acc > 0);
          w_state_nxt  = StStep;
        end
      end
      StStep: begin
        // Timer counts cycles since the ps_en pulse, the pulse cycle included.
        w_timer_nxt = r_timer + TMR_W'(1);
        w_state_nxt = StWait;
      end
      StWait: begin
        if (ps_done) begin
          if (r_incdec) begin
            if (r_count != PSCNT_MAX) w_count_nxt = r_count + PSCNT_W'(1);
          end else begin
            if (r_count != PSCNT_MIN) w_count_nxt = r_count - PSCNT_W'(1);
          end
          w_steps_nxt = r_steps - STEP_W'(1);
          w_state_nxt = (r_steps != STEP_W'(1) && servo_en) ? StStep : StAccum;
        end else if (r_timer == TMR_W'(PS_TIMEOUT - 1)) begin
          w_tout_nxt   = 1'b1;
          w_locked_nxt = 1'b0;
          w_quiet_nxt  = '0;
          w_steps_nxt  = '0;
          w_state_nxt  = StAccum;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = StAccum;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= StAccum;
      r_acc    <= '0;
      r_scnt   <= '0;
      r_quiet  <= '0;
      r_steps  <= '0;
      r_timer  <= '0;
      r_incdec <= 1'b0;
      r_locked <= 1'b0;
      r_count  <= '0;
      r_tout   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_scnt   <= w_scnt_nxt;
      r_quiet  <= w_quiet_nxt;
      r_steps  <= w_steps_nxt;
      r_timer  <= w_timer_nxt;
      r_incdec <= w_incdec_nxt;
      r_locked <= w_locked_nxt;
      r_count  <= w_count_nxt;
      r_tout   <= w_tout_nxt;
    end
  end

  assign ps_en       = (r_state == StStep);
  assign ps_incdec   = r_incdec;
  assign locked      = r_locked;
  assign ps_count    = r_count;
  assign timeout_err = r_tout;

endmodule

// File: tb/tb_mmcm_ps_servo.sv
// Directed bench for mmcm_ps_servo. An MMCM model answers each ps_en with a
// ps_done three cycles later, and a pulse monitor counts ps_en activity.
module tb_mmcm_ps_servo;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              servo_en;
  logic              err_valid;
  logic signed [7:0] err_in;
  logic              ps_en;
  logic              ps_incdec;
  logic              ps_done;
  logic              locked;
  logic signed [15:0] ps_count;
  logic              timeout_err;

  logic resp_en = 1'b0;
  logic resp_done = 1'b0;
  logic man_done = 1'b0;
  assign ps_done = resp_done | man_done;

  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;
  int n_inc = 0;
  int n_viol = 0;
  int base_p;
  int base_i;

  mmcm_ps_servo dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .servo_en    (servo_en),
    .err_valid   (err_valid),
    .err_in      (err_in),
    .ps_en       (ps_en),
    .ps_incdec   (ps_incdec),
    .ps_done     (ps_done),
    .locked      (locked),
    .ps_count    (ps_count),
    .timeout_err (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  // MMCM model: ps_done is sampled on the 4th rising edge after the ps_en cycle
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_in);
      resp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) resp_done = 1'b1;
      end
      if (resp_en && ps_en) cnt = 3;
    end
  end

  // Pulse monitor: counts ps_en pulses and back-to-back assertions
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk_in);
      if (ps_en === 1'b1) begin
        n_pulse++;
        if (ps_incdec === 1'b1) n_inc++;
        if (prev_en) n_viol++;
      end
      prev_en = (ps_en === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      err_valid = 1'b1;
      err_in    = v[7:0];
      tick();
    end
    err_valid = 1'b0;
    err_in    = '0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in  = 1'b1;
    servo_en  = 1'b1;
    err_valid = 1'b0;
    err_in    = '0;
    repeat (3) tick();
    reset_in = 1'b0;
    chk("rst_ps_en", int'(ps_en), 0);
    chk("rst_incdec", int'(ps_incdec), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_count", int'(ps_count), 0);
    chk("rst_tout", int'(timeout_err), 0);

    // Window of +1 x64: acc=64 -> 16 steps, capped to 8 increments
    resp_en = 1'b1;
    base_p = n_pulse; base_i = n_inc;
    send(64, 1);
    chk("t1_decide_no_en", int'(ps_en), 0);
    tick();
    chk("t1_first_en", int'(ps_en), 1);
    chk("t1_incdec", int'(ps_incdec), 1);
    repeat (40) tick();
    chk("t1_pulses", n_pulse - base_p, 8);
    chk("t1_incs", n_inc - base_i, 8);
    chk("t1_count", int'(ps_count), 8);
    chk("t1_locked", int'(locked), 0);

    // Sum -12 -> 3 decrements; then sum +5 -> 1 increment
    do_reset();
    base_p = n_pulse; base_i = n_inc;
    send(12, -1);
    send(52, 0);
    repeat (30) tick();
    chk("t2_pulses", n_pulse - base_p, 3);
    chk("t2_incs", n_inc - base_i, 0);
    chk("t2_count", int'(ps_count), -3);
    base_p = n_pulse; base_i = n_inc;
    send(5, 1);
    send(59, 0);
    repeat (20) tick();
    chk("t2b_pulses", n_pulse - base_p, 1);
    chk("t2b_incs", n_inc - base_i, 1);
    chk("t2b_count", int'(ps_count), -2);

    // Four quiet windows (+3) reach lock; a +40 window breaks it
    do_reset();
    base_p = n_pulse;
    for (int w = 0; w < 3; w++) begin
      send(3, 1);
      send(61, 0);
      tick();
      tick();
      chk("t3_not_locked", int'(locked), 0);
    end
    send(3, 1);
    send(61, 0);
    chk("t3_decide_locked", int'(locked), 0);
    tick();
    chk("t3_locked_rise", int'(locked), 1);
    chk("t3_no_pulses", n_pulse - base_p, 0);
    repeat (3) tick();
    send(40, 1);
    send(24, 0);
    chk("t3_still_locked", int'(locked), 1);
    tick();
    chk("t3_locked_fall", int'(locked), 0);
    chk("t3_step_en", int'(ps_en), 1);
    repeat (40) tick();
    chk("t3_count", int'(ps_count), 8);

    // ps_done withheld: timeout exactly 64 cycles after ps_en
    do_reset();
    resp_en = 1'b0;
    base_p = n_pulse;
    send(64, 1);
    tick();
    chk("t4_en", int'(ps_en), 1);
    repeat (63) tick();
    chk("t4_tout_early", int'(timeout_err), 0);
    tick();
    chk("t4_tout", int'(timeout_err), 1);
    chk("t4_count", int'(ps_count), 0);
    chk("t4_locked", int'(locked), 0);
    repeat (10) tick();
    chk("t4_single_pulse", n_pulse - base_p, 1);
    resp_en = 1'b1;
    send(64, 1);
    repeat (40) tick();
    chk("t4_recover_count", int'(ps_count), 8);
    chk("t4_tout_sticky", int'(timeout_err), 1);

    // Reset in WAIT, then a stray ps_done
    do_reset();
    resp_en = 1'b0;
    send(64, 1);
    tick();
    chk("t5_en", int'(ps_en), 1);
    tick();
    tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    chk("t5_ps_en", int'(ps_en), 0);
    chk("t5_incdec", int'(ps_incdec), 0);
    chk("t5_tout", int'(timeout_err), 0);
    chk("t5_locked", int'(locked), 0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t5_count_stray", int'(ps_count), 0);
    base_p = n_pulse;
    send(63, 1);
    repeat (5) tick();
    chk("t5_no_early_en", n_pulse - base_p, 0);
    resp_en = 1'b1;
    send(1, 1);
    tick();
    chk("t5_window_en", int'(ps_en), 1);
    repeat (40) tick();
    chk("t5_count", int'(ps_count), 8);

    // servo_en low discards samples; dropping it mid-burst stops after 2 steps
    do_reset();
    servo_en = 1'b0;
    base_p = n_pulse;
    send(128, 10);
    repeat (5) tick();
    chk("t6_disabled", n_pulse - base_p, 0);
    servo_en = 1'b1;
    base_p = n_pulse;
    send(64, 1);
    tick();
    chk("t6_step1", int'(ps_en), 1);
    repeat (4) tick();
    chk("t6_step2", int'(ps_en), 1);
    tick();
    servo_en = 1'b0;
    repeat (20) tick();
    chk("t6_pulses", n_pulse - base_p, 2);
    chk("t6_count", int'(ps_count), 2);
    servo_en = 1'b1;

    chk("no_b2b_ps_en", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmcm_ps_servo.md
Name: mmcm_ps_servo

Overview:
Closed-loop phase servo controller for the slave MMCM. It consumes signed phase-error samples from the upstream phase detector and accumulates them over a fixed window. It then drives the MMCM dynamic phase-shift port (PSEN/PSINCDEC/PSDONE) with a bounded number of fine steps per window. It also reports lock status and the net phase offset applied.

Parameters:
ERR_W, 8, width of signed err_in
ACC_W, 16, width of signed window accumulator (saturating)
WINDOW, 64, err_valid samples per accumulation window
DEADBAND, 4, |acc| <= DEADBAND means no correction
GAIN_SHIFT, 2, steps = |acc| >> GAIN_SHIFT
MAX_STEPS, 8, cap on steps issued per window
PS_TIMEOUT, 64, clk_in cycles to wait for ps_done before abandoning
LOCK_WINDOWS, 4, consecutive quiet windows required to assert locked
PSCNT_W, 16, width of signed ps_count

Ports:
clk_in  in  1  MMCM DRP/PS clock; all logic on rising edge
reset_in  in  1  synchronous, active-high reset
servo_en  in  1  1 = corrections allowed
err_valid  in  1  err_in qualifier, single-cycle per sample
err_in  in  ERR_W  signed phase error; positive = slave lags master
ps_en  out  1  MMCM PSEN, one-cycle pulse per step
ps_incdec  out  1  MMCM PSINCDEC, 1 = increment
ps_done  in  1  MMCM PSDONE
locked  out  1  servo converged
ps_count  out  PSCNT_W  signed net steps completed (saturating)
timeout_err  out  1  sticky: ps_done missing within PS_TIMEOUT

Behaviour:
- Reset: all outputs 0, acc=0, sample_cnt=0, quiet_cnt=0, state=ACCUM. Reset applies at any state, including mid-WAIT; ps_done arriving after reset is ignored.
- ACCUM:
  - On err_valid, acc += sign-extended err_in, saturating at ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)), and sample_cnt++.
  - The sample that makes sample_cnt == WINDOW moves the state to DECIDE on the next cycle.
  - If servo_en=0: acc and sample_cnt are held at 0 and samples are discarded.
- DECIDE (1 cycle):
  - Computes steps = min(MAX_STEPS, max(1, |acc|>>GAIN_SHIFT)) and dir = (acc>0).
  - If |acc| <= DEADBAND: no step; quiet_cnt++ (saturates at LOCK_WINDOWS). locked=1 once quiet_cnt reaches LOCK_WINDOWS.
  - Otherwise: locked=0, quiet_cnt=0, steps_left=steps, ps_incdec=dir, go to STEP.
  - Both branches clear acc and sample_cnt; the no-step branch returns to ACCUM.
- STEP: ps_en=1 for exactly this cycle; next state WAIT; timeout counter cleared.
- WAIT:
  - ps_incdec is held stable from STEP until ps_done.
  - On ps_done: ps_count ±1 (saturating, sign per ps_incdec), steps_left--. Go to STEP if steps_left != 0 and servo_en=1, else ACCUM.
  - ps_done on the same cycle the timeout count reaches PS_TIMEOUT counts as done (no error).
  - On timeout: timeout_err=1 (sticky until reset), locked=0, quiet_cnt=0, remaining steps abandoned, return to ACCUM.
- servo_en falling mid-correction: the in-flight step completes (WAIT honoured), no further STEP, return to ACCUM.
- err_valid outside ACCUM: sample discarded, not counted.
- ps_done outside WAIT: ignored.
- ps_en is never asserted in two consecutive cycles and never asserted while a previous step is outstanding.
- Latency from the WINDOW-th sample to the first ps_en is 2 cycles (DECIDE, then STEP).

Test Plan:
- 64 samples err_in=+1, ps_done 3 cycles after each ps_en -> acc=64, 8 ps_en pulses (capped by MAX_STEPS) with ps_incdec=1; ps_count=+8; locked=0.
- 64 samples summing to -12 -> 3 pulses with ps_incdec=0; ps_count=-3; next window summing to +5 -> 1 increment pulse, ps_count=-2.
- 4 consecutive windows each summing to +3 -> no ps_en ever; locked rises 1 cycle after 4th window's final sample; one window of sum +40 -> locked falls in DECIDE.
- 64 samples err_in=+1, ps_done withheld -> single ps_en; timeout_err=1 exactly 64 cycles later; ps_count=0; returns to ACCUM; next window with ps_done works, timeout_err stays 1.
- reset_in pulsed during WAIT, then ps_done -> all outputs 0 after reset edge; ps_count stays 0; no ps_en until a full new window completes.
- servo_en=0 for 128 samples of err_in=+10 -> no ps_en; servo_en deasserted during 2nd of 8 steps -> exactly 2 steps complete, ps_count=+2.
